// File: rtl/count_timer_pkg.sv
// Shared constants, FSM encodings and helpers for the count_timer_arbiter block.
// The ARB_FIXED_PRIO_EN build option is handled in rr_arbiter and count_timer_arbiter.
package count_timer_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned CNT_W_DEF = 3;
    localparam int unsigned NREQ_MAX  = 8;
    localparam int unsigned IDX_W_MAX = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One-hot decode sized for the largest supported requester count
    function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDX_W_MAX-1:0] idx);
        return NREQ_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/count_timer_arbiter_if.sv
// Requester-side bus of the shared counter timer: requests/limits in, grant/done/count/busy out.
interface count_timer_arbiter_if
    import count_timer_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] limit;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [CNT_W-1:0]      count;
    logic                  busy;

    modport master (
        output req, limit,
        input  gnt, done, count, busy
    );

    modport slave (
        input  req, limit,
        output gnt, done, count, busy
    );

endinterface

// File: rtl/count_timer_arbiter_rr_arbiter.sv
// Combinational winner select: round-robin from ptr_i+1, or lowest index when
// ARB_FIXED_PRIO_EN is defined (pointer input removed in that build).
module rr_arbiter
    import count_timer_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
`ifndef ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [NREQ-1:0]  gnt_c_o,
    output logic [IDX_W-1:0] idx_c_o
);

    logic found;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        found   = 1'b0;
        idx_c_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_i[IDX_W'(k)]) begin
                found   = 1'b1;
                idx_c_o = IDX_W'(k);
            end
        end
    end
`else
    // Search starts just after the last winner and wraps, so it ends on the pointer itself
    always_comb begin
        int unsigned j;
        found   = 1'b0;
        idx_c_o = '0;
        j       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            j = (32'(ptr_i) + k) % NREQ;
            if (!found && req_i[IDX_W'(j)]) begin
                found   = 1'b1;
                idx_c_o = IDX_W'(j);
            end
        end
    end
`endif

    assign gnt_c_o = found ? NREQ'(onehot(IDX_W_MAX'(idx_c_o))) : '0;

endmodule

// File: rtl/count_timer_arbiter.sv
// Shares one up-counter between NREQ requesters: arbitrate, count 0..limit, pulse done.
// Build option ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module count_timer_arbiter
    import count_timer_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    count_timer_arbiter_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(NREQ);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    logic [1:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [NREQ-1:0]  done_q,  done_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] lim_q,   lim_d;
    logic             busy_q,  busy_d;
    logic [IDX_W-1:0] win_q,   win_d;

    logic [NREQ-1:0]  arb_gnt_c;
    logic [IDX_W-1:0] arb_idx_c;
    logic [CNT_W-1:0] lim_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lim
        assign lim_arr[g] = bus.limit[g*CNT_W +: CNT_W];
    end

    // win_q also serves as the round-robin pointer
    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (bus.req),
`ifndef ARB_FIXED_PRIO_EN
        .ptr_i   (win_q),
`endif
        .gnt_c_o (arb_gnt_c),
        .idx_c_o (arb_idx_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        busy_d  = busy_q;
        win_d   = win_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req != '0) begin
                    win_d   = arb_idx_c;
                    gnt_d   = arb_gnt_c;
                    lim_d   = lim_arr[arb_idx_c];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.req[win_q]) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == lim_q) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            busy_q  <= 1'b0;
            win_q   <= IDX_LAST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = cnt_q;
    assign bus.busy  = busy_q;

    // Grant integrity: never multi-hot, done only to the current owner
    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
    assert property (@(posedge clk) disable iff (!reset_n) (done_d & ~gnt_q) == '0);

endmodule

// File: tb/tb_count_timer_arbiter.sv
// Self-checking bench for count_timer_arbiter: per-cycle behavioural model plus directed literals.
module tb_count_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 3;
    localparam int LW    = NREQ * CNT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_timer_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

    count_timer_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner (-1 = nobody), elapsed count, latched limit, done mask, cooldown cycles
    int m_owner, m_count, m_lim, m_done, m_cool, m_last;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_count = 0;
        m_lim   = 0;
        m_done  = 0;
        m_cool  = 0;
        m_last  = NREQ - 1;
    endtask

    function automatic int pick(input int reqv, input int last);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++)
            if (((reqv >> i) % 2) == 1) return i;
`else
        for (int k = 1; k <= NREQ; k++)
            if (((reqv >> ((last + k) % NREQ)) % 2) == 1) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic model_step();
        int reqv;
        reqv   = 32'(bus.req);
        m_done = 0;
        if (m_owner >= 0) begin
            if (((reqv >> m_owner) % 2) == 0) begin
                m_owner = -1;
                m_count = 0;
            end else if (m_count == m_lim) begin
                m_done  = 1 << m_owner;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_count = m_count + 1;
            end
        end else if (m_cool > 0) begin
            m_cool  = m_cool - 1;
            m_count = 0;
        end else if (reqv != 0) begin
            m_owner = pick(reqv, m_last);
            m_last  = m_owner;
            m_lim   = (32'(bus.limit) >> (m_owner * CNT_W)) % (1 << CNT_W);
            m_count = 0;
        end
    endtask

    task automatic compare();
        check("gnt",   32'(bus.gnt),   (m_owner >= 0) ? (1 << m_owner) : 0);
        check("done",  32'(bus.done),  m_done);
        check("count", 32'(bus.count), m_count);
        check("busy",  32'(bus.busy),  (m_owner >= 0) ? 1 : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_lim(input int i, input int v);
        logic [LW-1:0] mask;
        mask      = LW'((1 << CNT_W) - 1) << (i * CNT_W);
        bus.limit = (bus.limit & ~mask) | ((LW'(v) << (i * CNT_W)) & mask);
    endtask

    function automatic int idx_of(input int oh);
        for (int i = 0; i < NREQ; i++)
            if (((oh >> i) % 2) == 1) return i;
        return -1;
    endfunction

    task automatic sync_reset();
        rst_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Runs one grant to completion, drops req on done, then two settling cycles
    task automatic run_grant(input string tag, input int budget,
                             output int gcyc, output int dcyc, output int maxc, output int late0);
        bit seen = 1'b0;
        int n    = 0;
        gcyc = 0; dcyc = 0; maxc = 0; late0 = 0;
        while (!seen && n < budget) begin
            cyc();
            n++;
            if (bus.gnt != '0) begin
                gcyc++;
                if (32'(bus.count) > maxc) maxc = 32'(bus.count);
                if (gcyc > 1 && 32'(bus.count) == 0) late0++;
            end
            if (bus.done != '0) begin
                dcyc++;
                seen    = 1'b1;
                bus.req = '0;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        repeat (2) begin
            cyc();
            if (bus.done != '0) dcyc++;
        end
    endtask

    initial begin
        int gc, dc, mc, lz, n, prev, dsum;
        int order[$];
        int exp_order[5];

        bus.req   = '1;
        bus.limit = '0;
        model_reset();

        // Reset held with every requester asking
        repeat (3) cyc();
        check("rst_gnt",   32'(bus.gnt),   0);
        check("rst_done",  32'(bus.done),  0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_busy",  32'(bus.busy),  0);
        rst_n   = 1'b1;
        bus.req = '0;
        cyc();

        // Single request, limit 5
        set_lim(0, 5);
        bus.req = 4'b0001;
        run_grant("single", 30, gc, dc, mc, lz);
        check("single_gnt_cycles", gc, 6);
        check("single_done_cycles", dc, 1);
        check("single_max_count", mc, 5);

        // Contention from a fresh reset, all limits 1
        sync_reset();
        bus.limit = LW'(12'o1111);
        bus.req   = '1;
        prev = 0;
        n    = 0;
        while (order.size() < 5 && n < 60) begin
            cyc();
            n++;
            if (prev == 0 && bus.gnt != '0) order.push_back(idx_of(32'(bus.gnt)));
            prev = 32'(bus.gnt);
        end
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        check("cont_num_grants", order.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) check($sformatf("cont_order%0d", i), order[i], exp_order[i]);
        bus.req = '0;
        repeat (4) cyc();

        // Boundary limits: 0 and max
        bus.limit = '0;
        bus.req   = 4'b0100;
        run_grant("lim0", 20, gc, dc, mc, lz);
        check("lim0_gnt_cycles", gc, 1);
        check("lim0_done_cycles", dc, 1);
        set_lim(3, 7);
        bus.req = 4'b1000;
        run_grant("lim7", 30, gc, dc, mc, lz);
        check("lim7_gnt_cycles", gc, 8);
        check("lim7_max_count", mc, 7);
        check("lim7_late_zero", lz, 0);
        check("lim7_done_cycles", dc, 1);

        // Abort at count 2
        set_lim(1, 6);
        bus.req = 4'b0010;
        n = 0;
        while (!(bus.gnt != '0 && 32'(bus.count) == 2) && n < 20) begin
            cyc();
            n++;
        end
        check("abort_reach_count", 32'(bus.count), 2);
        bus.req = '0;
        cyc();
        check("abort_gnt",   32'(bus.gnt),   0);
        check("abort_count", 32'(bus.count), 0);
        check("abort_busy",  32'(bus.busy),  0);
        dsum = 32'(bus.done);
        repeat (4) begin
            cyc();
            dsum = dsum | 32'(bus.done);
        end
        check("abort_no_done", dsum, 0);

        // Limit change ignored while running
        set_lim(1, 4);
        bus.req = 4'b0010;
        n = 0;
        while (bus.gnt == '0 && n < 10) begin
            cyc();
            n++;
        end
        check("lchg_start_count", 32'(bus.count), 0);
        set_lim(1, 1);
        run_grant("lchg", 20, gc, dc, mc, lz);
        check("lchg_remaining_gnt", gc, 4);
        check("lchg_max_count", mc, 4);
        check("lchg_done_cycles", dc, 1);

        // Asynchronous reset mid-RUN at count 3
        set_lim(3, 7);
        bus.req = 4'b1000;
        n = 0;
        while (!(bus.gnt != '0 && 32'(bus.count) == 3) && n < 20) begin
            cyc();
            n++;
        end
        check("async_reach_count", 32'(bus.count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt",   32'(bus.gnt),   0);
        check("async_done",  32'(bus.done),  0);
        check("async_count", 32'(bus.count), 0);
        check("async_busy",  32'(bus.busy),  0);
        model_reset();
        bus.req = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, expected end before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
